// File: rtl/pipeline_mem_pkg.sv
// pipeline_mem_pkg: shared size codes, FSM state encoding and helpers for the MEM stage.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package pipeline_mem_pkg;

  // Memory access size codes shared by the load (mre) and store (mwe) fields
  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam logic        Enable   = 1'b1;
  localparam logic        Disable  = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_t;

  // Index of the final byte of an access of the given size
  function automatic logic [1:0] last_byte_idx(input logic [1:0] sz);
    logic [1:0] idx;
    case (sz)
      SZ_HALF: idx = 2'd1;
      SZ_WORD: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Natural-alignment test on the low address bits
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] addr_lo);
    logic bad;
    case (sz)
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/pipeline_mem_if.sv
// pipeline_mem_if: byte-serial request/acknowledge memory port of the MEM stage.
// Latency: ack may arrive in the same cycle as the request, or any later cycle.
// Backpressure: requester holds req/addr/wdata stable until ack.
interface pipeline_mem_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic [7:0]  mem_rdata_i;
  logic        mem_ack_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_wdata_o,
    input  mem_rdata_i,
    input  mem_ack_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_wdata_o,
    output mem_rdata_i,
    output mem_ack_i
  );
endinterface

// File: rtl/pipeline_mem_load_ext.sv
// mem_load_ext: selects the loaded bytes and sign/zero extends them to 32 bits.
// Latency: combinational.
// Backpressure: none.
module mem_load_ext
  import pipeline_mem_pkg::*;
(
  input  logic [31:0] i_buf,
  input  logic [1:0]  i_size,
  input  logic        i_sign,
  output logic [31:0] o_data
);

  // Extend from bit 7 for bytes, bit 15 for halves; words pass through
  always_comb begin
    o_data = i_buf;
    case (i_size)
      SZ_BYTE: o_data = {{24{i_sign & i_buf[7]}}, i_buf[7:0]};
      SZ_HALF: o_data = {{16{i_sign & i_buf[15]}}, i_buf[15:0]};
      default: o_data = i_buf;
    endcase
  end

endmodule

// File: rtl/pipeline_mem.sv
// pipeline_mem: RV32I memory-access stage; byte-serial loads/stores between EX and WB.
// Latency: 1 cycle for non-memory ops; 1 + N + 1 cycles (+ack waits) for an N-byte access.
// Backpressure: stall_o high while an access is in flight; honours stall_i[3] (bubble) and stall_i[4] (hold).
// Option: define MEM_ALIGN_CHECK_EN to reject misaligned half/word accesses without a bus request.
module pipeline_mem
  import pipeline_mem_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [4:0]     rd_i,
  input  logic           we_i,
  input  logic [31:0]    wdata_i,
  input  logic [1:0]     mre_i,
  input  logic           mrsign_i,
  input  logic [1:0]     mwe_i,
  input  logic [31:0]    mwdata_i,
  input  logic [31:0]    ma_i,
  input  logic [4:0]     stall_i,
  output logic           stall_o,
  output logic [4:0]     rd_o,
  output logic           we_o,
  output logic [31:0]    wdata_o,
  output logic           misalign_o,
  pipeline_mem_if.master bus
);

  mem_state_t  r_state;
  mem_state_t  w_state_nxt;
  logic [1:0]  r_cnt;
  logic [1:0]  w_cnt_nxt;
  logic        r_misal;
  logic        w_misal_nxt;
  logic        w_misal_pulse;
  logic [31:0] r_buf;
  logic [4:0]  r_rd;
  logic        r_we;
  logic [31:0] r_wdata;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_pending;
  logic [1:0]  w_size;
  logic        w_last;
  logic        w_misalign;
  logic        w_in_access;
  logic        w_take_byte;
  logic [31:0] w_ext;
  logic [31:0] w_load_val;
  logic        w_unused;

  assign w_is_load   = (mre_i != SZ_NONE);
  assign w_is_store  = (mwe_i != SZ_NONE);
  assign w_pending   = w_is_load | w_is_store;
  assign w_size      = w_is_load ? mre_i : mwe_i;
  assign w_last      = (r_cnt == last_byte_idx(w_size));
  assign w_in_access = (r_state == ST_ACCESS);
  assign w_take_byte = w_in_access & bus.mem_ack_i;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_pending & is_misaligned(w_size, ma_i[1:0]);
`else
  assign w_misalign = Disable;
`endif

  // Lower stall bits belong to earlier stages and are not used here
  assign w_unused = ^stall_i[2:0];

  // Stall is combinational so the request is seen in the first cycle of the access
  assign stall_o    = w_pending & (r_state != ST_DONE);
  assign misalign_o = w_misal_pulse;

  // Bus drive: address and data follow the byte counter and stay put until ack
  assign bus.mem_req_o   = w_in_access;
  assign bus.mem_we_o    = w_in_access & w_is_store;
  assign bus.mem_addr_o  = ma_i + {30'd0, r_cnt};
  assign bus.mem_wdata_o = w_in_access ? mwdata_i[{r_cnt, 3'b000} +: 8] : 8'h00;

  mem_load_ext u_load_ext (
    .i_buf  (r_buf),
    .i_size (mre_i),
    .i_sign (mrsign_i),
    .o_data (w_ext)
  );

  // A rejected misaligned load writes back zero
  assign w_load_val = r_misal ? ZeroWord : w_ext;

  // Next-state logic: IDLE -> ACCESS (byte loop) -> DONE, or IDLE -> DONE on misalignment
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_misal_nxt   = r_misal;
    w_misal_pulse = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_misal_nxt = 1'b0;
        if (w_pending) begin
          if (w_misalign) begin
            w_state_nxt   = ST_DONE;
            w_misal_nxt   = 1'b1;
            w_misal_pulse = 1'b1;
          end else begin
            w_state_nxt = ST_ACCESS;
            w_cnt_nxt   = 2'd0;
          end
        end
      end
      ST_ACCESS: begin
        if (bus.mem_ack_i) begin
          w_cnt_nxt = r_cnt + 2'd1;
          if (w_last) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (!stall_i[3]) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, byte counter and misalignment flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
      r_misal <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_misal <= w_misal_nxt;
    end
  end

  // Little-endian load assembly: each acked byte lands at its counter position
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf <= ZeroWord;
    end else if (w_take_byte && w_is_load) begin
      r_buf[{r_cnt, 3'b000} +: 8] <= bus.mem_rdata_i;
    end
  end

  // Results to WB / EX forwarding: bubble, hold, load, store, or pass-through
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd    <= 5'd0;
      r_we    <= Disable;
      r_wdata <= ZeroWord;
    end else if (stall_i[3] && !stall_i[4]) begin
      r_rd    <= 5'd0;
      r_we    <= Disable;
      r_wdata <= ZeroWord;
    end else if (stall_i[4]) begin
      r_rd    <= r_rd;
      r_we    <= r_we;
      r_wdata <= r_wdata;
    end else if (w_is_load) begin
      r_rd    <= rd_i;
      r_we    <= we_i;
      r_wdata <= w_load_val;
    end else if (w_is_store) begin
      r_rd    <= 5'd0;
      r_we    <= Disable;
      r_wdata <= ZeroWord;
    end else begin
      r_rd    <= rd_i;
      r_we    <= we_i;
      r_wdata <= wdata_i;
    end
  end

  assign rd_o    = r_rd;
  assign we_o    = r_we;
  assign wdata_o = r_wdata;

endmodule
